// File: rtl/pad_mux_ctrl_if.sv
// pad_mux_ctrl_if: configuration port of the pad mux controller.
//   cfg_req_i  request, held high by the master until cfg_ack_o
//   cfg_pad_i  pad index to reassign
//   cfg_sel_i  new owning source for that pad
//   cfg_ack_o  one-cycle completion pulse
//   cfg_err_o  valid with cfg_ack_o, set when the request was illegal
//   busy_o     high while a reassignment sequence is in flight
// Handshake: the master raises cfg_req_i with stable cfg_pad_i/cfg_sel_i and
// keeps it high until it sees cfg_ack_o; the request is taken only while the
// controller is idle, and a request still high in the cycle after the ack is
// treated as a new one.
interface pad_mux_ctrl_if #(
  parameter int PadW = 3,
  parameter int SelW = 2
);
  logic            cfg_req_i;
  logic [PadW-1:0] cfg_pad_i;
  logic [SelW-1:0] cfg_sel_i;
  logic            cfg_ack_o;
  logic            cfg_err_o;
  logic            busy_o;

  modport master (
    output cfg_req_i, cfg_pad_i, cfg_sel_i,
    input  cfg_ack_o, cfg_err_o, busy_o
  );

  modport slave (
    input  cfg_req_i, cfg_pad_i, cfg_sel_i,
    output cfg_ack_o, cfg_err_o, busy_o
  );
endinterface

// File: rtl/pad_mux_ctrl.sv
// pad_mux_ctrl: runtime pin-mux between NSrc sources and NPads pads.
// Every pad has exactly one owning source (source 0 after reset). Changing an
// owner runs break-before-make on that pad only: OE held low for DeadCycles,
// then the select switches, then the new owner's input stays at IdleIn for
// SettleCycles so its synchronisers never see a stale edge.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   cfg            configuration port (pad_mux_ctrl_if.slave)
//   pad_sel_o      current owner per pad, pad i at [i*SelW +: SelW]
//   src_out_i      source output data, source s / pad i at bit s*NPads+i
//   src_oe_i       source output enables, same packing
//   src_in_o       pad input routed back to the sources, same packing
//   pad_out_o      to padring pad_out
//   pad_oe_o       to padring pad_oe
//   pad_in_i       from padring pad_in
//   dbg_state_o    controller state (0 idle, 1 break, 2 switch, 3 settle, 4 ack)
module pad_mux_ctrl #(
  parameter int               NPads        = 8,
  parameter int               NSrc         = 4,
  parameter int               DeadCycles   = 4,
  parameter int               SettleCycles = 2,
  parameter logic [NPads-1:0] IdleIn       = '1,
  localparam int              PadW         = $clog2(NPads),
  localparam int              SelW         = $clog2(NSrc)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  pad_mux_ctrl_if.slave           cfg,
  output logic [NPads*SelW-1:0]   pad_sel_o,
  input  logic [NSrc*NPads-1:0]   src_out_i,
  input  logic [NSrc*NPads-1:0]   src_oe_i,
  output logic [NSrc*NPads-1:0]   src_in_o,
  output logic [NPads-1:0]        pad_out_o,
  output logic [NPads-1:0]        pad_oe_o,
  input  logic [NPads-1:0]        pad_in_i,
  output logic [2:0]              dbg_state_o
);

  localparam int CntMax = (DeadCycles > SettleCycles) ? DeadCycles : SettleCycles;
  localparam int CntW   = (CntMax < 2) ? 1 : $clog2(CntMax);
  localparam logic [CntW-1:0] DeadLoad   = CntW'(DeadCycles - 1);
  localparam logic [CntW-1:0] SettleLoad = CntW'((SettleCycles > 0) ? SettleCycles - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BREAK  = 3'd1,
    ST_SWITCH = 3'd2,
    ST_SETTLE = 3'd3,
    ST_ACK    = 3'd4
  } state_e;

  state_e                         state_q, state_d;
  logic [NPads-1:0][SelW-1:0]     sel_q, sel_d;
  logic [PadW-1:0]                pad_q, pad_d;
  logic [SelW-1:0]                new_q, new_d;
  logic [CntW-1:0]                cnt_q, cnt_d;
  logic                           err_q, err_d;

  logic req_legal;
  logic oe_block;
  logic in_mask;

  // Range checks use 32-bit compares so that a power-of-two pad or source
  // count (where every encoding is legal) does not wrap the limit to zero.
  assign req_legal = (32'(cfg.cfg_pad_i) < NPads) && (32'(cfg.cfg_sel_i) < NSrc);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    pad_d   = pad_q;
    new_d   = new_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cfg.cfg_req_i) begin
          pad_d = cfg.cfg_pad_i;
          new_d = cfg.cfg_sel_i;
          err_d = 1'b0;
          if (!req_legal) begin
            err_d   = 1'b1;
            state_d = ST_ACK;
          end else if (cfg.cfg_sel_i == sel_q[cfg.cfg_pad_i]) begin
            // Already owned by the requested source: nothing to break.
            state_d = ST_ACK;
          end else begin
            state_d = ST_BREAK;
            cnt_d   = DeadLoad;
          end
        end
      end
      ST_BREAK: begin
        if (cnt_q == '0) state_d = ST_SWITCH;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_SWITCH: begin
        sel_d[pad_q] = new_q;
        if (SettleCycles == 0) begin
          state_d = ST_ACK;
        end else begin
          state_d = ST_SETTLE;
          cnt_d   = SettleLoad;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) state_d = ST_ACK;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      pad_q   <= '0;
      new_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      pad_q   <= pad_d;
      new_q   <= new_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // OE of the target pad is blocked until the new select is in place; its
  // input stays masked one phase longer, through the settle window.
  assign oe_block = (state_q == ST_BREAK) || (state_q == ST_SWITCH);
  assign in_mask  = oe_block || (state_q == ST_SETTLE);

  always_comb begin
    pad_out_o = '0;
    pad_oe_o  = '0;
    src_in_o  = {NSrc{IdleIn}};
    for (int i = 0; i < NPads; i++) begin
      for (int s = 0; s < NSrc; s++) begin
        if (sel_q[i] == SelW'(s)) begin
          pad_out_o[i] = src_out_i[s*NPads+i];
          pad_oe_o[i]  = src_oe_i[s*NPads+i] & ~(oe_block && (pad_q == PadW'(i)));
          if (!(in_mask && (pad_q == PadW'(i)))) begin
            src_in_o[s*NPads+i] = pad_in_i[i];
          end
        end
      end
    end
  end

  assign pad_sel_o     = sel_q;
  assign cfg.cfg_ack_o = (state_q == ST_ACK);
  assign cfg.cfg_err_o = (state_q == ST_ACK) && err_q;
  assign cfg.busy_o    = (state_q != ST_IDLE);
  assign dbg_state_o   = state_q;

endmodule
